img_bank_mgr: RTL and testbench

- Parametrised image-bank address manager for the slideshow datapath.
- Counts pixels arriving from the SPI slave and tracks the load phase, latched through an FSM.
- Keeps one current-image index per read channel, driven by touch gestures, for NUM_CH channels.
- Outputs per-channel SDRAM read base/max addresses and the read-FIFO reload pulse to the SDRAM controller. It has no SDRAM pins itself.

---
 rtl/img_bank_mgr.sv | 218 +++++++++++++++++++++
 tb/tb_img_bank_mgr.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/img_bank_mgr.sv
// Image-bank address manager: tracks pixel loading through an FSM, keeps one image index per read channel and
// publishes per-channel SDRAM read windows. Define IMG_AUTOPLAY_EN to add frame-driven automatic image advance.
module img_bank_mgr #(
  parameter int NUM_CH        = 2,
  parameter int IMG_W         = 5,
  parameter int ADDR_W        = 24,
  parameter int PIX_PER_IMG   = 384000,
  parameter int WORDS_PER_PIX = 2,
  parameter int LOAD_DLY      = 50,
  parameter int AUTO_FRAMES   = 120
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [7:0]                iImg_Tot,
  input  logic                      iTrigger,
  input  logic                      iGest_E,
  input  logic                      iGest_W,
  input  logic                      iNew_Frame,
  input  logic                      iEnd_Frame,
  output logic                      oLoading,
  output logic                      oReady,
  output logic [31:0]               oPix_Cnt,
  output logic [ADDR_W-1:0]         oWr_Max_Addr,
  output logic [NUM_CH*IMG_W-1:0]   oCur_Img,
  output logic [NUM_CH*ADDR_W-1:0]  oRd_Base_Addr,
  output logic [NUM_CH*ADDR_W-1:0]  oRd_Max_Addr,
  output logic                      oRd_Load
);

  localparam int MAX_IMG = 2 ** IMG_W;
  localparam int TOT_W   = IMG_W + 1;
  localparam logic [ADDR_W-1:0] RANGE = ADDR_W'(64'(PIX_PER_IMG) * 64'(WORDS_PER_PIX));
  localparam logic [31:0]       PPI32 = 32'(PIX_PER_IMG);
  localparam int SET_W = (LOAD_DLY > 1) ? $clog2(LOAD_DLY) : 1;
  localparam logic [SET_W-1:0] SET_LAST = (LOAD_DLY > 1) ? SET_W'(LOAD_DLY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_LOADING, S_SETTLE, S_READY} state_t;

  state_t              state_q, state_d;
  logic [TOT_W-1:0]    tot_q, tot_d, tot_clamp;
  logic [31:0]         pix_cnt_q, pix_cnt_d;
  logic [31:0]         pix_tgt_q, pix_tgt_new;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [ADDR_W-1:0]   wr_max_q, wr_max_d;
  logic                loading_q, ready_q, rd_load_q;
  logic                ready_entry;
  logic                in_ready, gest_e, gest_w, auto_w, step_w, step_e;
  logic [NUM_CH-1:0][IMG_W-1:0] seed;

  assign tot_clamp   = ({24'd0, iImg_Tot} > 32'(MAX_IMG)) ? TOT_W'(MAX_IMG) : TOT_W'(iImg_Tot);
  assign pix_tgt_q   = 32'(tot_q) * PPI32;
  assign pix_tgt_new = 32'(tot_clamp) * PPI32;

  always_comb begin
    state_d     = state_q;
    tot_d       = tot_q;
    pix_cnt_d   = pix_cnt_q;
    settle_d    = settle_q;
    wr_max_d    = wr_max_q;
    ready_entry = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iTrigger && (iImg_Tot != 8'd0)) begin
          tot_d     = tot_clamp;
          pix_cnt_d = 32'd1;
          settle_d  = '0;
          wr_max_d  = ADDR_W'(tot_clamp) * RANGE;
          state_d   = (pix_tgt_new <= 32'd1) ? S_SETTLE : S_LOADING;
        end
      end
      S_LOADING: begin
        if (iTrigger && (pix_cnt_q < pix_tgt_q)) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          if (pix_cnt_q + 32'd1 == pix_tgt_q) begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          settle_d    = '0;
          state_d     = S_READY;
          ready_entry = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      tot_q     <= '0;
      pix_cnt_q <= '0;
      settle_q  <= '0;
      wr_max_q  <= '0;
      loading_q <= 1'b0;
      ready_q   <= 1'b0;
      rd_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tot_q     <= tot_d;
      pix_cnt_q <= pix_cnt_d;
      settle_q  <= settle_d;
      wr_max_q  <= wr_max_d;
      loading_q <= (state_d == S_LOADING) || (state_d == S_SETTLE);
      ready_q   <= (state_d == S_READY);
      rd_load_q <= iNew_Frame;
    end
  end

  // Opposing gestures in the same cycle cancel out.
  assign in_ready = (state_q == S_READY);
  assign gest_e   = in_ready & iGest_E & ~iGest_W;
  assign gest_w   = in_ready & iGest_W & ~iGest_E;

`ifdef IMG_AUTOPLAY_EN
  localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = (AUTO_FRAMES > 1) ? FC_W'(AUTO_FRAMES - 1) : '0;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            user_gest;

  assign user_gest = in_ready & (iGest_E | iGest_W);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    auto_w      = 1'b0;
    if (user_gest) begin
      frame_cnt_d = '0;
    end else if (in_ready && iEnd_Frame) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        auto_w      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign auto_w = 1'b0;
`endif

  assign step_w = gest_w | auto_w;
  assign step_e = gest_e;

  // Starting index of channel k on entry to READY is k mod tot_q, built by repeated wrap-increment.
  always_comb begin : seed_calc
    logic [IMG_W-1:0] v;
    logic [TOT_W-1:0] nxt;
    v    = '0;
    nxt  = '0;
    seed = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      seed[k] = v;
      nxt     = {1'b0, v} + 1'b1;
      v       = (nxt == tot_q) ? '0 : nxt[IMG_W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [IMG_W-1:0]  idx_q, idx_d, idx_inc, idx_dec;
      logic [ADDR_W-1:0] base_q, max_q, base_d;

      assign idx_inc = (({1'b0, idx_q} + 1'b1) == tot_q) ? '0 : idx_q + 1'b1;
      assign idx_dec = (idx_q == '0) ? IMG_W'(tot_q - 1'b1) : idx_q - 1'b1;
      assign base_d  = ADDR_W'(idx_q) * RANGE;

      always_comb begin
        idx_d = idx_q;
        if (ready_entry) begin
          idx_d = seed[gi];
        end else if (step_w) begin
          idx_d = idx_inc;
        end else if (step_e) begin
          idx_d = idx_dec;
        end
      end

      // Addresses sample the pre-update index so a gesture never shifts the frame being closed.
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          idx_q  <= IMG_W'(gi % MAX_IMG);
          base_q <= '0;
          max_q  <= RANGE;
        end else begin
          idx_q <= idx_d;
          if (iEnd_Frame) begin
            base_q <= base_d;
            max_q  <= base_d + RANGE;
          end
        end
      end

      assign oCur_Img[gi*IMG_W +: IMG_W]         = idx_q;
      assign oRd_Base_Addr[gi*ADDR_W +: ADDR_W] = base_q;
      assign oRd_Max_Addr[gi*ADDR_W +: ADDR_W]  = max_q;
    end
  endgenerate

  assign oLoading     = loading_q;
  assign oReady       = ready_q;
  assign oPix_Cnt     = pix_cnt_q;
  assign oWr_Max_Addr = wr_max_q;
  assign oRd_Load     = rd_load_q;

endmodule

// File: tb/tb_img_bank_mgr.sv
// Randomized scoreboard bench for img_bank_mgr: a behavioural model predicts every cycle's outputs,
// a monitor compares them on the falling edge. Autoplay checks follow IMG_AUTOPLAY_EN.
module tb_img_bank_mgr;
  localparam int NUM_CH = 2, IMG_W = 5, ADDR_W = 24, PPI = 4, WPP = 2, LOAD_DLY = 3, AUTO_FRAMES = 2;
  localparam int RANGE = PPI * WPP;
  localparam int MAX_IMG = 2 ** IMG_W;

  logic iCLK, iRST, iTrigger, iGest_E, iGest_W, iNew_Frame, iEnd_Frame;
  logic [7:0] iImg_Tot;
  logic oLoading, oReady, oRd_Load;
  logic [31:0] oPix_Cnt;
  logic [ADDR_W-1:0] oWr_Max_Addr;
  logic [NUM_CH*IMG_W-1:0] oCur_Img;
  logic [NUM_CH*ADDR_W-1:0] oRd_Base_Addr, oRd_Max_Addr;

  img_bank_mgr #(
    .NUM_CH(NUM_CH), .IMG_W(IMG_W), .ADDR_W(ADDR_W), .PIX_PER_IMG(PPI),
    .WORDS_PER_PIX(WPP), .LOAD_DLY(LOAD_DLY), .AUTO_FRAMES(AUTO_FRAMES)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iImg_Tot(iImg_Tot), .iTrigger(iTrigger),
    .iGest_E(iGest_E), .iGest_W(iGest_W), .iNew_Frame(iNew_Frame), .iEnd_Frame(iEnd_Frame),
    .oLoading(oLoading), .oReady(oReady), .oPix_Cnt(oPix_Cnt), .oWr_Max_Addr(oWr_Max_Addr),
    .oCur_Img(oCur_Img), .oRd_Base_Addr(oRd_Base_Addr), .oRd_Max_Addr(oRd_Max_Addr), .oRd_Load(oRd_Load)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic loading, ready;
    logic [31:0] pix;
    logic [ADDR_W-1:0] wr_max;
    logic [NUM_CH*IMG_W-1:0] cur;
    logic [NUM_CH*ADDR_W-1:0] base, maxa;
    logic rd_load;
  } snap_t;

  snap_t exp_q[$];
  event async_ev;
  int n_vec = 0, n_err = 0;
  logic [7:0] tot_in;

  // Model: 0 idle, 1 loading, 2 settle, 3 ready.
  int m_phase, m_pix, m_tot, m_settle, m_fc, m_rdload;
  int m_idx[NUM_CH], m_base[NUM_CH], m_max[NUM_CH];

  function automatic void model_reset();
    m_phase = 0; m_pix = 0; m_tot = 0; m_settle = 0; m_fc = 0; m_rdload = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_idx[k] = k % MAX_IMG; m_base[k] = 0; m_max[k] = RANGE;
    end
  endfunction

  function automatic void model_apply(bit trig, bit e, bit w, bit nf, bit ef, int tin);
    int step;
    step = 0;
    m_rdload = nf;
    if (ef) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_base[k] = (m_idx[k] * RANGE) % (1 << ADDR_W);
        m_max[k]  = (m_base[k] + RANGE) % (1 << ADDR_W);
      end
    end
    case (m_phase)
      0: if (trig && tin != 0) begin
           m_tot = (tin > MAX_IMG) ? MAX_IMG : tin;
           m_pix = 1; m_settle = 0;
           m_phase = (m_pix >= m_tot * PPI) ? 2 : 1;
         end
      1: if (trig && m_pix < m_tot * PPI) begin
           m_pix++;
           if (m_pix == m_tot * PPI) begin m_phase = 2; m_settle = 0; end
         end
      2: begin
           m_settle++;
           if (m_settle == LOAD_DLY) begin
             m_phase = 3;
             for (int k = 0; k < NUM_CH; k++) m_idx[k] = k % m_tot;
           end
         end
      default: begin
           if (e && !w) step = -1;
           else if (w && !e) step = 1;
`ifdef IMG_AUTOPLAY_EN
           if (e || w) m_fc = 0;
           else if (ef) begin
             m_fc++;
             if (m_fc == AUTO_FRAMES) begin m_fc = 0; step = 1; end
           end
`endif
           for (int k = 0; k < NUM_CH; k++) m_idx[k] = (m_idx[k] + step + m_tot) % m_tot;
         end
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    s.loading = (m_phase == 1) || (m_phase == 2);
    s.ready   = (m_phase == 3);
    s.pix     = 32'(m_pix);
    s.wr_max  = ADDR_W'((m_tot * RANGE) % (1 << ADDR_W));
    s.rd_load = (m_rdload != 0);
    for (int k = 0; k < NUM_CH; k++) begin
      s.cur[k*IMG_W +: IMG_W]    = IMG_W'(m_idx[k]);
      s.base[k*ADDR_W +: ADDR_W] = ADDR_W'(m_base[k]);
      s.maxa[k*ADDR_W +: ADDR_W] = ADDR_W'(m_max[k]);
    end
    return s;
  endfunction

  task automatic drive(input bit trig, input bit e, input bit w, input bit nf, input bit ef);
    @(negedge iCLK); #1;
    iRST = 1'b0; iTrigger = trig; iGest_E = e; iGest_W = w;
    iNew_Frame = nf; iEnd_Frame = ef; iImg_Tot = tot_in;
    model_apply(trig, e, w, nf, ef, int'(tot_in));
    exp_q.push_back(model_snap());
  endtask

  // Reset is raised between clock edges and checked before the next rising edge.
  task automatic async_reset();
    @(negedge iCLK); #1;
    iRST = 1'b1; iTrigger = 0; iGest_E = 0; iGest_W = 0; iNew_Frame = 0; iEnd_Frame = 0;
    model_reset();
    exp_q.push_back(model_snap());
    #2;
    -> async_ev;
    exp_q.push_back(model_snap());
  endtask

  task automatic run_load();
    for (int c = 0; c < 2000 && m_phase != 3; c++) begin
      if (m_phase != 0) tot_in = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic run_ready(input int n);
    for (int c = 0; c < n; c++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge iCLK or async_ev);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        n_vec++;
        cmp("loading", 64'(oLoading), 64'(s.loading));
        cmp("ready", 64'(oReady), 64'(s.ready));
        cmp("pix_cnt", 64'(oPix_Cnt), 64'(s.pix));
        cmp("wr_max", 64'(oWr_Max_Addr), 64'(s.wr_max));
        cmp("cur_img", 64'(oCur_Img), 64'(s.cur));
        cmp("rd_base", 64'(oRd_Base_Addr), 64'(s.base));
        cmp("rd_max", 64'(oRd_Max_Addr), 64'(s.maxa));
        cmp("rd_load", 64'(oRd_Load), 64'(s.rd_load));
      end
    end
  end

  initial begin : stimulus
    int totv[3];
    iRST = 0; iTrigger = 0; iGest_E = 0; iGest_W = 0; iNew_Frame = 0; iEnd_Frame = 0;
    iImg_Tot = 0; tot_in = 0;
    model_reset();
    async_reset();
    // Empty bank announced: triggers must not start loading.
    tot_in = 8'd0;
    repeat (6) drive($urandom_range(0, 1) != 0, 0, 0, 0, 0);
    tot_in = 8'd3;
    drive(1, 0, 0, 0, 0);
    run_load();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    run_ready(80);
    // Abort a load part-way through.
    tot_in = 8'($urandom_range(4, 8));
    drive(1, 0, 0, 0, 0);
    repeat (5) drive($urandom_range(0, 1) != 0, 0, 0, 0, 0);
    async_reset();
    totv[0] = 1; totv[1] = 2; totv[2] = 40;
    for (int t = 0; t < 3; t++) begin
      tot_in = 8'(totv[t]);
      drive(1, 0, 0, 0, 0);
      run_load();
      run_ready(60);
      async_reset();
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge iCLK);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
